// File: rtl/if_pkg.sv
// if_pkg: shared IF-stage widths, next-PC source indices and PC-register FSM states
package if_pkg;
    localparam int IF_WIDTH   = 32;
    localparam int IF_NUM_SRC = 4;
    localparam int SRC_PC4    = 0;
    localparam int SRC_BRANCH = 1;
    localparam int SRC_JUMP   = 2;
    localparam int SRC_EXC    = 3;
    typedef enum logic {RUN, PEND} pc_state_e;
endpackage

// File: rtl/nway_mux.sv
// nway_mux: combinational NUM_SRC:1 mux with in-range flag; out-of-range sel yields source 0
module nway_mux
    import if_pkg::*;
#(
    parameter int WIDTH = IF_WIDTH,
    parameter int NUM_SRC = IF_NUM_SRC,
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         dout,
    output logic                     in_range
);
    always_comb begin
        in_range = 32'(sel) < NUM_SRC;
        dout = src_data[WIDTH-1:0];
        for (int i = 1; i < NUM_SRC; i++)
            dout = (sel == SEL_W'(i)) ? src_data[i*WIDTH +: WIDTH] : dout;
    end
endmodule

// File: rtl/pc_src_mux_reg.sv
// pc_src_mux_reg: registered N-way next-PC selector with stall hold, buffered redirect; PC_SRC_MUX_ERR_EN enables sel range checking
module pc_src_mux_reg
    import if_pkg::*;
#(
    parameter int WIDTH = IF_WIDTH,
    parameter int NUM_SRC = IF_NUM_SRC,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_addr,
    output logic [WIDTH-1:0]         pc_out,
    output logic                     pc_valid,
    output logic                     redirect_pend,
    output logic                     sel_err
);
    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d, pc_q, pc_d, mux_out;
    logic             valid_q, valid_d, err_q, err_d, in_range;

    nway_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) u_mux (
        .src_data(src_data),
        .sel(sel),
        .dout(mux_out),
        .in_range(in_range)
    );

`ifndef PC_SRC_MUX_ERR_EN
    logic unused_in_range;
    assign unused_in_range = in_range;
`endif

    always_comb begin
        state_d = state_q;
        pend_d = pend_q;
        pc_d = pc_q;
        valid_d = valid_q;
        err_d = err_q;
        if (redirect && stall) begin
            pend_d = redirect_addr;
            state_d = PEND;
        end else if (redirect) begin
            pc_d = redirect_addr;
            valid_d = 1'b1;
            state_d = RUN;
        end else if (!stall && state_q == PEND) begin
            pc_d = pend_q;
            valid_d = 1'b1;
            state_d = RUN;
`ifdef PC_SRC_MUX_ERR_EN
        end else if (!stall && !in_range) begin
            valid_d = 1'b0;
            err_d = 1'b1;
`endif
        end else if (!stall) begin
            pc_d = mux_out;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pend_q <= '0;
            pc_q <= RESET_VAL;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            pc_q <= pc_d;
            valid_q <= valid_d;
            err_q <= err_d;
        end
    end

    assign pc_out = pc_q;
    assign pc_valid = valid_q;
    assign redirect_pend = (state_q == PEND);
    assign sel_err = err_q;
endmodule

// File: tb/tb_pc_src_mux_reg.sv
// tb_pc_src_mux_reg: scoreboard bench, directed test-plan sequences then random traffic
module tb_pc_src_mux_reg;
    localparam int W = 5;
    localparam int N = 3;

    typedef struct {
        logic [W-1:0] pc;
        logic         v, p, e;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst, stall, redirect;
    logic [N*W-1:0] src_data;
    logic [1:0]     sel;
    logic [W-1:0]   redirect_addr, pc_out;
    logic           pc_valid, redirect_pend, sel_err;

    logic [W-1:0] src [N];
    logic [W-1:0] m_pc, m_pa;
    logic         m_v, m_p, m_e;
    exp_t         sb[$];
    int           n_vec = 0;
    int           n_bad = 0;

    pc_src_mux_reg #(.WIDTH(W), .NUM_SRC(N), .RESET_VAL(5'b00000)) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .sel(sel), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr), .pc_out(pc_out),
        .pc_valid(pc_valid), .redirect_pend(redirect_pend), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            chk("pc_out", pc_out, e.pc);
            chk("pc_valid", W'(pc_valid), W'(e.v));
            chk("redirect_pend", W'(redirect_pend), W'(e.p));
            chk("sel_err", W'(sel_err), W'(e.e));
        end
    end

    task automatic cyc(input logic r, input logic st, input logic rd, input logic [W-1:0] ra, input logic [1:0] s);
        @(negedge clk);
        rst = r; stall = st; redirect = rd; redirect_addr = ra; sel = s;
        src_data = {src[2], src[1], src[0]};
        if (r) begin
            m_pc = '0; m_v = 0; m_e = 0; m_p = 0; m_pa = '0;
        end else if (rd && st) begin
            m_pa = ra; m_p = 1;
        end else if (rd) begin
            m_pc = ra; m_v = 1; m_p = 0;
        end else if (!st && m_p) begin
            m_pc = m_pa; m_v = 1; m_p = 0;
        end else if (!st && int'(s) < N) begin
            m_pc = src[s]; m_v = 1;
        end else if (!st) begin
`ifdef PC_SRC_MUX_ERR_EN
            m_v = 0; m_e = 1;
`else
            m_pc = src[0]; m_v = 1;
`endif
        end
        sb.push_back('{m_pc, m_v, m_p, m_e});
    endtask

    initial begin
        src[0] = 5'b01010; src[1] = 5'b10101; src[2] = 5'b11111;
        m_pc = '0; m_pa = '0; m_v = 0; m_p = 0; m_e = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < N; k++) src[k] = W'($urandom);
            cyc(0, 1, 0, 0, 2'($urandom_range(0, 2)));
        end
        cyc(0, 0, 0, 0, 2);
        cyc(0, 1, 1, 5'b00101, 0);
        cyc(0, 1, 1, 5'b11101, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 5'b10001, 2);
        cyc(0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 5'b01111, 0);
        cyc(0, 0, 0, 0, 3);
        cyc(0, 1, 1, 5'b10011, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) src[k] = W'($urandom);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                W'($urandom), 2'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
